// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter with watchdog.
//   arb_state_e : arbiter FSM states
//   CTI_*       : Wishbone B3 cycle type encodings
//   clog2       : ceiling log2 for sizing index and counter fields
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin picker.
//   req_i   : request vector, one bit per requester
//   last_i  : index of the most recent winner
//   valid_o : at least one request is present
//   idx_o   : first requester found scanning last_i+1, last_i+2, ... (mod N)
module rr_prio_pick
    import wb_arb_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    // Walk offsets from farthest to nearest so the nearest requester is written last.
    always_comb begin
        int unsigned   j;
        logic [IW-1:0] jj;
        valid_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        jj      = '0;
        for (int unsigned k = N; k >= 1; k--) begin
            j  = (32'(last_i) + k) % N;
            jj = IW'(j);
            if (req_i[jj]) begin
                valid_o = 1'b1;
                idx_o   = jj;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter_wdt.sv
// Round-robin Wishbone B3 arbiter sharing one slave between NUM_MASTERS masters,
// with a bus watchdog that aborts unanswered accesses after TIMEOUT wait cycles.
//   wb_clk_i / wb_rst_i : clock, synchronous active-high reset
//   wbm_*_i / wbm_*_o   : packed per-master buses, master i at [i*W +: W]
//   wbs_*_o / wbs_*_i   : shared slave request / response
//   grant_o             : one-hot owner (0 when idle)
//   timeout_o           : one-cycle pulse on each watchdog abort
module wb_rr_arbiter_wdt
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 32,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,

    input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
    output logic [NUM_MASTERS*DW-1:0]   wbm_dat_o,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    output logic [NUM_MASTERS-1:0]      wbm_rty_o,

    output logic [AW-1:0]               wbs_adr_o,
    output logic [DW-1:0]               wbs_dat_o,
    output logic [DW/8-1:0]             wbs_sel_o,
    output logic                        wbs_we_o,
    output logic                        wbs_cyc_o,
    output logic                        wbs_stb_o,
    output logic [2:0]                  wbs_cti_o,
    output logic [1:0]                  wbs_bte_o,
    input  logic [DW-1:0]               wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    input  logic                        wbs_rty_i,

    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        timeout_o
);

    localparam int unsigned SW   = DW / 8;
    localparam int unsigned IW   = (NUM_MASTERS > 1) ? clog2(NUM_MASTERS) : 1;
    localparam int unsigned CW_R = clog2(TIMEOUT + 1);
    localparam int unsigned CW   = (CW_R > 0) ? CW_R : 1;

    localparam logic [CW-1:0] WDT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WDT_MAX  = '1;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] last_q, last_d;
    logic [CW-1:0] wdt_q, wdt_d;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] src;
    logic          resp;

    // Per-master views of the packed request buses.
    logic [AW-1:0] adr_a [NUM_MASTERS];
    logic [DW-1:0] dat_a [NUM_MASTERS];
    logic [SW-1:0] sel_a [NUM_MASTERS];
    logic [2:0]    cti_a [NUM_MASTERS];
    logic [1:0]    bte_a [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign adr_a[i] = wbm_adr_i[i*AW +: AW];
        assign dat_a[i] = wbm_dat_i[i*DW +: DW];
        assign sel_a[i] = wbm_sel_i[i*SW +: SW];
        assign cti_a[i] = wbm_cti_i[i*3 +: 3];
        assign bte_a[i] = wbm_bte_i[i*2 +: 2];
    end

    rr_prio_pick #(
        .N (NUM_MASTERS)
    ) u_pick (
        .req_i   (wbm_cyc_i),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // State, owner, rotation pointer and watchdog registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(NUM_MASTERS - 1);
            wdt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wdt_q   <= wdt_d;
        end
    end

    // Next-state, watchdog and response routing.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        wdt_d     = '0;
        src       = '0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        grant_o   = '0;
        timeout_o = 1'b0;
        resp      = wbs_ack_i | wbs_err_i | wbs_rty_i;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_BUSY;
                    gnt_d   = pick_idx;
                    last_d  = pick_idx;
                end
            end

            ST_BUSY: begin
                src               = gnt_q;
                grant_o           = NUM_MASTERS'(1) << gnt_q;
                wbs_cyc_o         = wbm_cyc_i[gnt_q];
                wbs_stb_o         = wbm_stb_i[gnt_q];
                wbm_ack_o[gnt_q]  = wbs_ack_i;
                wbm_err_o[gnt_q]  = wbs_err_i;
                wbm_rty_o[gnt_q]  = wbs_rty_i;
                if (!wbm_cyc_i[gnt_q]) begin
                    state_d = ST_IDLE;
                end else if (wbm_stb_i[gnt_q] && !resp) begin
                    // A response on the last allowed wait cycle wins over the abort.
                    if ((TIMEOUT != 0) && (wdt_q == WDT_LAST)) begin
                        state_d = ST_ABORT;
                    end else if (wdt_q != WDT_MAX) begin
                        wdt_d = wdt_q + CW'(1);
                    end else begin
                        wdt_d = wdt_q;
                    end
                end
            end

            ST_ABORT: begin
                // Slave is cut off for one cycle; its late responses are dropped.
                src              = gnt_q;
                grant_o          = NUM_MASTERS'(1) << gnt_q;
                wbm_err_o[gnt_q] = 1'b1;
                timeout_o        = 1'b1;
                state_d          = wbm_cyc_i[gnt_q] ? ST_BUSY : ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset silences the bus in the same cycle it is asserted.
        if (wb_rst_i) begin
            src       = '0;
            wbs_cyc_o = 1'b0;
            wbs_stb_o = 1'b0;
            wbm_ack_o = '0;
            wbm_err_o = '0;
            wbm_rty_o = '0;
            grant_o   = '0;
            timeout_o = 1'b0;
        end
    end

    // Slave request fields follow the owner (master 0 when idle).
    assign wbs_adr_o = adr_a[src];
    assign wbs_dat_o = dat_a[src];
    assign wbs_sel_o = sel_a[src];
    assign wbs_we_o  = wbm_we_i[src];
    assign wbs_cti_o = cti_a[src];
    assign wbs_bte_o = bte_a[src];

    // Read data is broadcast; only the owner sees an ack.
    assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};

endmodule

// File: tb/tb_wb_rr_arbiter_wdt.sv
module tb_wb_rr_arbiter_wdt;
    import wb_arb_pkg::*;

    logic        clk;
    logic        rst;

    // DUT with TIMEOUT=16
    logic [63:0] m_adr, m_dat, m_dat_o;
    logic [7:0]  m_sel;
    logic [1:0]  m_we, m_cyc, m_stb, m_ack, m_err, m_rty;
    logic [5:0]  m_cti;
    logic [3:0]  m_bte;
    logic [31:0] s_adr, s_dat_o, s_dat_i;
    logic [3:0]  s_sel;
    logic        s_we, s_cyc, s_stb, s_ack, s_err, s_rty;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;
    logic [1:0]  grant;
    logic        tmo;

    // DUT with watchdog disabled
    logic [63:0] z_adr, z_dat, z_dat_o;
    logic [7:0]  z_sel;
    logic [1:0]  z_we, z_cyc, z_stb, z_mack, z_merr, z_mrty;
    logic [5:0]  z_cti;
    logic [3:0]  z_bte;
    logic [31:0] z_sadr, z_sdat_o, z_sdat_i;
    logic [3:0]  z_ssel;
    logic        z_swe, z_scyc, z_sstb, z_ack, z_err, z_rty;
    logic [2:0]  z_scti;
    logic [1:0]  z_sbte;
    logic [1:0]  z_grant;
    logic        z_tmo;

    int n_cmp;
    int n_bad;

    wb_rr_arbiter_wdt #(.NUM_MASTERS(2), .DW(32), .AW(32), .TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
        .wbm_dat_o(m_dat_o), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
        .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_o), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
        .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
        .wbs_dat_i(s_dat_i), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .grant_o(grant), .timeout_o(tmo)
    );

    wb_rr_arbiter_wdt #(.NUM_MASTERS(2), .DW(32), .AW(32), .TIMEOUT(0)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(z_adr), .wbm_dat_i(z_dat), .wbm_sel_i(z_sel), .wbm_we_i(z_we),
        .wbm_cyc_i(z_cyc), .wbm_stb_i(z_stb), .wbm_cti_i(z_cti), .wbm_bte_i(z_bte),
        .wbm_dat_o(z_dat_o), .wbm_ack_o(z_mack), .wbm_err_o(z_merr), .wbm_rty_o(z_mrty),
        .wbs_adr_o(z_sadr), .wbs_dat_o(z_sdat_o), .wbs_sel_o(z_ssel), .wbs_we_o(z_swe),
        .wbs_cyc_o(z_scyc), .wbs_stb_o(z_sstb), .wbs_cti_o(z_scti), .wbs_bte_o(z_sbte),
        .wbs_dat_i(z_sdat_i), .wbs_ack_i(z_ack), .wbs_err_i(z_err), .wbs_rty_i(z_rty),
        .grant_o(z_grant), .timeout_o(z_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change here, checks at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_all();
        tick();
        m_cyc = 2'b00;
        m_stb = 2'b00;
        s_ack = 1'b0;
        s_err = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        m_cyc = 2'b11;
        m_stb = 2'b11;
        tick();
        tick();
        @(negedge clk);
        n_cmp++; if (s_cyc !== 1'b0) begin n_bad++; $display("FAIL rst_scyc got %b exp 0", s_cyc); end
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL rst_grant got %b exp 00", grant); end
        n_cmp++; if ({m_ack, m_err, m_rty} !== 6'b0) begin n_bad++; $display("FAIL rst_resp got %b exp 0", {m_ack, m_err, m_rty}); end
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL rst_tmo got %b exp 0", tmo); end
        n_cmp++; if (s_adr !== 32'h1000_0000) begin n_bad++; $display("FAIL rst_sadr got %h exp 10000000", s_adr); end
        tick();
        rst   = 1'b0;
        m_cyc = 2'b00;
        m_stb = 2'b00;
        tick();
    endtask

    task automatic test_burst();
        logic [31:0] ea;
        logic [2:0]  ec;
        tick();
        m_cyc = 2'b11;
        m_stb = 2'b11;
        m_cti = {CTI_CLASSIC, CTI_INCR};
        @(negedge clk);
        n_cmp++; if (grant !== 2'b00 || s_cyc !== 1'b0) begin n_bad++; $display("FAIL arb_latency got grant=%b cyc=%b exp 00/0", grant, s_cyc); end
        for (int b = 0; b < 4; b++) begin
            tick();
            ea = 32'h1000_0000 + 32'(b * 4);
            ec = (b == 3) ? CTI_EOB : CTI_INCR;
            m_adr[31:0] = ea;
            m_cti[2:0]  = ec;
            s_ack   = 1'b1;
            s_dat_i = 32'hA000_0000 + 32'(b);
            @(negedge clk);
            n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL burst_grant beat %0d got %b exp 01", b, grant); end
            n_cmp++; if (s_adr !== ea || s_cti !== ec) begin n_bad++; $display("FAIL burst_req beat %0d got %h/%b exp %h/%b", b, s_adr, s_cti, ea, ec); end
            n_cmp++; if (m_ack !== 2'b01) begin n_bad++; $display("FAIL burst_ack beat %0d got %b exp 01", b, m_ack); end
            n_cmp++; if (m_dat_o !== {2{32'hA000_0000 + 32'(b)}}) begin n_bad++; $display("FAIL burst_rdata beat %0d got %h", b, m_dat_o); end
        end
        tick();
        m_cyc = 2'b10;
        m_stb = 2'b10;
        s_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (s_cyc !== 1'b0) begin n_bad++; $display("FAIL release_scyc got %b exp 0", s_cyc); end
        tick();
        @(negedge clk);
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL dead_cycle got %b exp 00", grant); end
        tick();
        m_adr[63:32] = 32'h2000_0010;
        s_ack = 1'b1;
        @(negedge clk);
        n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL m1_grant got %b exp 10", grant); end
        n_cmp++; if (s_adr !== 32'h2000_0010 || m_ack !== 2'b10) begin n_bad++; $display("FAIL m1_route got %h/%b exp 20000010/10", s_adr, m_ack); end
        release_all();
    endtask

    task automatic test_alternate();
        logic [1:0] e;
        for (int g = 0; g < 6; g++) begin
            e = (g % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            m_cyc = 2'b11;
            m_stb = 2'b11;
            s_ack = 1'b0;
            @(negedge clk);
            n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL alt_gap %0d got %b exp 00", g, grant); end
            tick();
            s_ack = 1'b1;
            @(negedge clk);
            n_cmp++; if (grant !== e || m_ack !== e) begin n_bad++; $display("FAIL alt_grant %0d got %b/%b exp %b", g, grant, m_ack, e); end
            tick();
            m_cyc = ~e;
            m_stb = ~e;
            s_ack = 1'b0;
            @(negedge clk);
            n_cmp++; if (s_cyc !== 1'b0) begin n_bad++; $display("FAIL alt_release %0d got %b exp 0", g, s_cyc); end
        end
        release_all();
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        tick();
        m_cyc = 2'b10;
        m_stb = 2'b10;
        m_we  = 2'b00;
        m_adr[63:32] = 32'h9000_0000;
        for (int k = 1; k <= 16; k++) begin
            tick();
            @(negedge clk);
            if (m_err !== 2'b00 || tmo !== 1'b0 || s_cyc !== 1'b1) early++;
            if (k == 1) begin
                n_cmp++; if (s_adr !== 32'h9000_0000 || grant !== 2'b10) begin n_bad++; $display("FAIL to_req got %h/%b exp 90000000/10", s_adr, grant); end
            end
        end
        n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL to_early got %0d bad cycles exp 0", early); end
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_err !== 2'b10 || tmo !== 1'b1) begin n_bad++; $display("FAIL to_abort got err=%b tmo=%b exp 10/1", m_err, tmo); end
        n_cmp++; if (s_cyc !== 1'b0 || s_stb !== 1'b0 || m_ack !== 2'b00) begin n_bad++; $display("FAIL to_cut got cyc=%b stb=%b ack=%b exp 0/0/00", s_cyc, s_stb, m_ack); end
        tick();
        s_ack = 1'b0;
        m_cyc = 2'b00;
        m_stb = 2'b00;
        @(negedge clk);
        n_cmp++; if (tmo !== 1'b0 || m_err !== 2'b00) begin n_bad++; $display("FAIL to_pulse got tmo=%b err=%b exp 0/00", tmo, m_err); end
        tick();
        m_cyc = 2'b01;
        m_stb = 2'b01;
        m_we  = 2'b01;
        m_adr[31:0] = 32'h1000_0040;
        m_dat[31:0] = 32'h1234_5678;
        m_sel = 8'h3F;
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        n_cmp++; if (grant !== 2'b01 || m_ack !== 2'b01 || m_err !== 2'b00) begin n_bad++; $display("FAIL to_after got grant=%b ack=%b err=%b", grant, m_ack, m_err); end
        n_cmp++; if (s_we !== 1'b1 || s_dat_o !== 32'h1234_5678 || s_sel !== 4'hF) begin n_bad++; $display("FAIL to_after_req got we=%b dat=%h sel=%h", s_we, s_dat_o, s_sel); end
        release_all();
        m_we = 2'b00;
    endtask

    task automatic test_ack_at_limit();
        int bad;
        bad = 0;
        tick();
        m_cyc = 2'b01;
        m_stb = 2'b01;
        for (int k = 1; k <= 15; k++) begin
            tick();
            @(negedge clk);
            if (m_err !== 2'b00 || tmo !== 1'b0) bad++;
        end
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_ack !== 2'b01 || m_err !== 2'b00 || tmo !== 1'b0) begin n_bad++; $display("FAIL lim_ack got ack=%b err=%b tmo=%b exp 01/00/0", m_ack, m_err, tmo); end
        tick();
        s_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (tmo !== 1'b0 || m_err !== 2'b00 || s_cyc !== 1'b1) begin n_bad++; $display("FAIL lim_noabort got tmo=%b err=%b cyc=%b exp 0/00/1", tmo, m_err, s_cyc); end
        for (int k = 2; k <= 15; k++) begin
            tick();
            @(negedge clk);
            if (m_err !== 2'b00 || tmo !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL lim_wait got %0d bad cycles exp 0", bad); end
        release_all();
    endtask

    task automatic test_reset_mid();
        tick();
        m_cyc = 2'b01;
        m_stb = 2'b01;
        m_cti[2:0] = CTI_INCR;
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_ack !== 2'b01) begin n_bad++; $display("FAIL rm_beat1 got %b exp 01", m_ack); end
        tick();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        s_ack = 1'b0;
        m_cyc = 2'b11;
        m_stb = 2'b11;
        @(negedge clk);
        n_cmp++; if (s_cyc !== 1'b0 || grant !== 2'b00 || m_ack !== 2'b00) begin n_bad++; $display("FAIL rm_after got cyc=%b grant=%b ack=%b exp 0/00/00", s_cyc, grant, m_ack); end
        tick();
        @(negedge clk);
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL rm_first got %b exp 01", grant); end
        release_all();
    endtask

    task automatic test_wdt_off();
        int bad;
        int lost;
        bad  = 0;
        lost = 0;
        tick();
        z_cyc = 2'b01;
        z_stb = 2'b01;
        for (int k = 0; k < 1000; k++) begin
            tick();
            @(negedge clk);
            if (z_merr !== 2'b00 || z_tmo !== 1'b0) bad++;
            if (z_grant !== 2'b01 || z_scyc !== 1'b1) lost++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL off_noerr got %0d bad cycles exp 0", bad); end
        n_cmp++; if (lost !== 0) begin n_bad++; $display("FAIL off_hold got %0d lost cycles exp 0", lost); end
        tick();
        z_ack = 1'b1;
        @(negedge clk);
        n_cmp++; if (z_mack !== 2'b01 || z_grant !== 2'b01) begin n_bad++; $display("FAIL off_ack got ack=%b grant=%b exp 01/01", z_mack, z_grant); end
        tick();
        z_cyc = 2'b00;
        z_stb = 2'b00;
        z_ack = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        m_adr   = {32'h2000_0000, 32'h1000_0000};
        m_dat   = {32'hBBBB_0000, 32'hAAAA_0000};
        m_sel   = 8'hFF;
        m_we    = 2'b00;
        m_cyc   = 2'b00;
        m_stb   = 2'b00;
        m_cti   = '0;
        m_bte   = '0;
        s_dat_i = '0;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_rty   = 1'b0;
        z_adr   = {32'h2000_0000, 32'h1000_0000};
        z_dat   = '0;
        z_sel   = 8'hFF;
        z_we    = 2'b00;
        z_cyc   = 2'b00;
        z_stb   = 2'b00;
        z_cti   = '0;
        z_bte   = '0;
        z_sdat_i = '0;
        z_ack   = 1'b0;
        z_err   = 1'b0;
        z_rty   = 1'b0;

        test_reset();
        test_burst();
        test_alternate();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        test_wdt_off();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter_wdt.md
Name: wb_rr_arbiter_wdt

Overview:
- Round-robin Wishbone B3 arbiter that shares one slave port, such as the main memory, between NUM_MASTERS masters, such as the or1200 data and instruction buses.
- A master keeps the grant for its whole cycle (cyc high), so bursts and RMW sequences stay atomic.
- A bus watchdog aborts any access the slave leaves unanswered for TIMEOUT cycles and returns err to the owning master, so a hung slave cannot lock the CPU.
- It sits between the per-master address decoders and the shared slave, as a drop-in for the plain arbiter.

Parameters:
- NUM_MASTERS, 2: number of requesting masters (>=2).
- DW, 32: data width.
- AW, 32: address width.
- TIMEOUT, 255: watchdog limit, counted in wait cycles (stb high, no response). 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- wbm_adr_i  in  NUM_MASTERS*AW  master addresses; master i occupies [i*AW +: AW]; same packing rule for all wbm_* ports
- wbm_dat_i  in  NUM_MASTERS*DW  master write data
- wbm_sel_i  in  NUM_MASTERS*DW/8  byte selects
- wbm_we_i / wbm_cyc_i / wbm_stb_i  in  NUM_MASTERS each  per-master we, cyc, stb
- wbm_cti_i  in  NUM_MASTERS*3  cycle type
- wbm_bte_i  in  NUM_MASTERS*2  burst type
- wbm_dat_o  out  NUM_MASTERS*DW  read data (slave data broadcast to all)
- wbm_ack_o / wbm_err_o / wbm_rty_o  out  NUM_MASTERS each  per-master responses
- wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o  out  AW/DW/DW/8/1/1/1/3/2  shared slave request
- wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i  in  DW/1/1/1  shared slave response
- grant_o  out  NUM_MASTERS  one-hot current owner (0 when idle)
- timeout_o  out  1  one-cycle pulse on each watchdog abort

Behaviour:
- State machine (registered): IDLE, BUSY, ABORT. Registers: state, gnt index, last_gnt pointer, watchdog counter.
- Reset: state=IDLE, last_gnt=NUM_MASTERS-1 (master 0 wins first), counter=0. In IDLE/reset all wbs_cyc_o/wbs_stb_o/wbm_ack_o/wbm_err_o/wbm_rty_o/grant_o/timeout_o=0; wbs_adr/dat/sel/we/cti/bte = master 0 fields.
- Reset asserted mid-operation: next edge forces IDLE; slave cyc drops that cycle; no response to any master.
- IDLE: if any wbm_cyc_i, pick the first requester scanning last_gnt+1, last_gnt+2, … (wrap modulo NUM_MASTERS). Register gnt; last_gnt<=pick; go to BUSY. Arbitration latency: 1 cycle from cyc to wbs_cyc_o.
- BUSY routing (combinational):
  - All wbs_* request outputs come from master gnt.
  - wbs_cyc_o = wbm_cyc_i[gnt].
  - wbm_ack/err/rty_o[gnt] = wbs_*_i.
  - Responses to other masters = 0.
  - grant_o = one-hot(gnt).
- BUSY exit: wbm_cyc_i[gnt]=0 -> IDLE. The slave sees cyc low in the same cycle. One dead cycle occurs before the next grant.
- Requests from other masters during BUSY are ignored (held pending) until the owner releases.
- Watchdog counter:
  - Increments each BUSY cycle with cyc&stb high and no ack/err/rty.
  - Clears on any response, on stb low, and on leaving BUSY.
  - Width clog2(TIMEOUT+1), saturating; no wrap.
- Watchdog trigger: counter==TIMEOUT-1 with no response this cycle and TIMEOUT!=0 -> next state ABORT. A slave response arriving in that same cycle wins: it is passed through, the counter clears, and there is no abort.
- ABORT (exactly 1 cycle):
  - wbs_cyc_o=wbs_stb_o=0.
  - wbm_err_o[gnt]=1; ack/rty=0.
  - timeout_o=1.
  - Slave responses in this cycle are discarded.
  - Next state: BUSY if wbm_cyc_i[gnt] still 1 (grant kept), else IDLE.
- Bursts: cti/bte are passed through unchanged. The arbiter never splits a cycle; the grant is held through cti=3'b111.
- Simultaneous requests in IDLE: resolved purely by rotation. With all masters requesting continuously, each master is granted once per NUM_MASTERS grants.

Decomposition:
- Package wb_arb_pkg:
  - state enum (IDLE, BUSY, ABORT)
  - CTI constants: CLASSIC=3'b000, INCR=3'b010, EOB=3'b111
  - function clog2
- Sub-module rr_prio_pick: combinational round-robin picker, parameter N; inputs req[N], last[clog2 N]; outputs valid and idx.
- Top: FSM, watchdog counter, and muxing. Expected size about 200 lines.

Test Plan:
- NUM_MASTERS=2, TIMEOUT=16. After reset, m0 and m1 both raise cyc at t0. m0 is granted at t0+1 (grant_o=2'b01). m0 performs a 4-beat INCR burst; the slave acks every cycle. m1 is granted one cycle after m0 drops cyc (grant_o=2'b10).
- Both masters request continuously for 6 cycles. The grant sequence is m0, m1, m0, m1, m0, m1, with one idle cycle between grants and no master granted twice in a row.
- m1 reads 0x90000000; the slave never responds. After 16 wait cycles, wbm_err_o[1]=1 and timeout_o=1 for 1 cycle with wbs_cyc_o=0. m1 then drops cyc, the FSM returns to IDLE, and a subsequent m0 access completes normally.
- The slave acks on exactly wait cycle 16 (counter==15). The ack reaches the master, no err is issued, and timeout_o stays 0.
- Assert wb_rst_i during the 2nd beat of an m0 burst. Next cycle: wbs_cyc_o=0 and grant_o=0. After release, m0 wins the first arbitration again (last_gnt reset).
- TIMEOUT=0: the slave stalls for 1000 cycles with no err and no timeout_o; the grant is held until the slave finally acks.
